// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA bus master: FSM state encoding,
// the supervisor-data function code and the default dtack timeout.
package dma_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_RD_ADDR,
        S_RD_STRB,
        S_RD_END,
        S_WR_ADDR,
        S_WR_STRB,
        S_WR_END,
        S_REL
    } dma_state_t;

    localparam logic [2:0] FC_SUPER_DATA   = 3'b101;
    localparam int         DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/dma_sync.sv
// Two-flop synchronizer for the asynchronous bus handshake inputs.
// RST_VAL is the idle level the chain resets to.
module dma_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_sync;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_sync <= {2{RST_VAL}};
        else        r_sync <= {r_sync[0], i_async};
    end

    assign o_sync = r_sync[1];

endmodule

// File: rtl/dma_bus_master.sv
// Word DMA engine acting as a 68000-style bus initiator (copy or fill).
// Fill mode is compiled in only when DMA_FILL_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | bus not requested; waits for start
// S_REQ     | br_n asserted; waits for grant and previous owner's as_n high
// S_ACK     | bgack_n asserted, drivers enabled, br_n released
// S_RD_ADDR | source address driven, strobes high (setup cycle)
// S_RD_STRB | as_n + read lanes low; waits for dtack_n or timeout
// S_RD_END  | strobes high (hold cycle); read word held in r_data
// S_WR_ADDR | destination address and data driven, strobes high
// S_WR_STRB | as_n + write lanes low; waits for dtack_n or timeout
// S_WR_END  | strobes high; count/addresses advance; abort checked here
// S_REL     | bgack_n and drivers released; done set unless error
module dma_bus_master
    import dma_pkg::*;
#(
    parameter int ADDR_W  = 23,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              start,
    input  logic              abort,
    input  logic              fill_mode,
    input  logic [15:0]       fill_pattern,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  remaining,
    output logic              br_n,
    input  logic              bg_n,
    output logic              bgack_n,
    input  logic              bus_as_n,
    output logic              m_oe,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_fc,
    output logic              m_as_n,
    output logic              m_rdh_n,
    output logic              m_rdl_n,
    output logic              m_wrh_n,
    output logic              m_wrl_n,
    output logic [15:0]       m_data_out,
    output logic              m_data_oe,
    input  logic [15:0]       m_data_in,
    input  logic              m_dtack_n
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    dma_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_src, r_dst, w_addr;
    logic [CNT_W-1:0]  r_rem, w_rem_dec;
    logic [15:0]       r_data;
    logic [TMR_W-1:0]  r_tmr;
    logic              r_fill, r_done, r_err;
    logic              w_bg_s, w_as_s, w_dtack_s, w_tmo, w_fill_mode;
    logic              w_own, w_br_n, w_as_n, w_rd_n, w_wr_n, w_data_oe;

    dma_sync u_sync_bg    (.sysclk(sysclk), .rst_n(rst_n), .i_async(bg_n),      .o_sync(w_bg_s));
    dma_sync u_sync_as    (.sysclk(sysclk), .rst_n(rst_n), .i_async(bus_as_n),  .o_sync(w_as_s));
    dma_sync u_sync_dtack (.sysclk(sysclk), .rst_n(rst_n), .i_async(m_dtack_n), .o_sync(w_dtack_s));

`ifdef DMA_FILL_EN
    assign w_fill_mode = fill_mode;
`else
    logic w_unused_fill;
    assign w_fill_mode   = 1'b0;
    assign w_unused_fill = ^{fill_mode, fill_pattern};
`endif

    assign w_tmo     = (r_tmr == '0);
    assign w_rem_dec = r_rem - 1'b1;

    always_comb begin
        w_next    = r_state;
        w_own     = 1'b0;
        w_br_n    = 1'b1;
        w_as_n    = 1'b1;
        w_rd_n    = 1'b1;
        w_wr_n    = 1'b1;
        w_data_oe = 1'b0;
        w_addr    = '0;
        unique case (r_state)
            S_IDLE:    if (start && word_count != '0) w_next = S_REQ;
            S_REQ: begin
                w_br_n = 1'b0;
                if (!w_bg_s && w_as_s) w_next = S_ACK;
            end
            S_ACK: begin
                w_own  = 1'b1;
                w_next = r_fill ? S_WR_ADDR : S_RD_ADDR;
            end
            S_RD_ADDR: begin
                w_own  = 1'b1;
                w_addr = r_src;
                w_next = S_RD_STRB;
            end
            S_RD_STRB: begin
                w_own  = 1'b1;
                w_addr = r_src;
                w_as_n = 1'b0;
                w_rd_n = 1'b0;
                if (!w_dtack_s) w_next = S_RD_END;
                else if (w_tmo) w_next = S_REL;
            end
            S_RD_END: begin
                w_own  = 1'b1;
                w_addr = r_src;
                w_next = S_WR_ADDR;
            end
            S_WR_ADDR: begin
                w_own     = 1'b1;
                w_addr    = r_dst;
                w_data_oe = 1'b1;
                w_next    = S_WR_STRB;
            end
            S_WR_STRB: begin
                w_own     = 1'b1;
                w_addr    = r_dst;
                w_as_n    = 1'b0;
                w_wr_n    = 1'b0;
                w_data_oe = 1'b1;
                if (!w_dtack_s) w_next = S_WR_END;
                else if (w_tmo) w_next = S_REL;
            end
            S_WR_END: begin
                w_own  = 1'b1;
                w_addr = r_dst;
                if (w_rem_dec == '0 || abort) w_next = S_REL;
                else                          w_next = r_fill ? S_WR_ADDR : S_RD_ADDR;
            end
            S_REL:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_rem  <= '0;
            r_data <= '0;
            r_tmr  <= '0;
            r_fill <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: if (start) begin
                    r_src  <= src_addr;
                    r_dst  <= dst_addr;
                    r_rem  <= word_count;
                    r_fill <= w_fill_mode;
                    r_done <= (word_count == '0);
                    r_err  <= 1'b0;
                end
                S_RD_STRB: begin
                    if (!w_dtack_s) r_data <= m_data_in;
                    else if (w_tmo) r_err  <= 1'b1;
                end
                S_WR_STRB: if (w_dtack_s && w_tmo) r_err <= 1'b1;
                S_WR_END: begin
                    r_rem <= w_rem_dec;
                    r_src <= r_src + 1'b1;
                    r_dst <= r_dst + 1'b1;
                end
                S_REL:   r_done <= !r_err;
                default: ;
            endcase
            // Timer reloads in each address cycle so every strobe phase gets a full budget.
            if (r_state == S_RD_ADDR || r_state == S_WR_ADDR)            r_tmr <= TMR_W'(TIMEOUT - 1);
            else if ((r_state == S_RD_STRB || r_state == S_WR_STRB) && !w_tmo) r_tmr <= r_tmr - 1'b1;
`ifdef DMA_FILL_EN
            if (r_fill && w_next == S_WR_ADDR) r_data <= fill_pattern;
`endif
        end
    end

    assign busy       = (r_state != S_IDLE) && (r_state != S_REL);
    assign done       = r_done;
    assign err        = r_err;
    assign remaining  = r_rem;
    assign br_n       = w_br_n;
    assign bgack_n    = !w_own;
    assign m_oe       = w_own;
    assign m_fc       = w_own ? FC_SUPER_DATA : 3'b000;
    assign m_addr     = w_addr;
    assign m_as_n     = w_as_n;
    assign m_rdh_n    = w_rd_n;
    assign m_rdl_n    = w_rd_n;
    assign m_wrh_n    = w_wr_n;
    assign m_wrl_n    = w_wr_n;
    assign m_data_out = r_data;
    assign m_data_oe  = w_data_oe;

endmodule

// File: tb/tb_dma_bus_master.sv
// Directed bench for dma_bus_master: bus arbiter + memory responder models,
// write scoreboard queue, immediate-assertion checks.
module tb_dma_bus_master;

    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [22:0] src_addr = '0, dst_addr = '0;
    logic [15:0] word_count = '0;
    logic        start = 1'b0, abort = 1'b0, fill_mode = 1'b0;
    logic [15:0] fill_pattern = '0;
    logic        busy, done, err;
    logic [15:0] remaining;
    logic        br_n, bgack_n, m_oe, m_as_n, m_rdh_n, m_rdl_n, m_wrh_n, m_wrl_n, m_data_oe;
    logic        bg_n = 1'b1, bus_as_n = 1'b1, m_dtack_n = 1'b1;
    logic [22:0] m_addr;
    logic [2:0]  m_fc;
    logic [15:0] m_data_out;
    logic [15:0] m_data_in = '0;

    dma_bus_master dut (
        .sysclk(sysclk), .rst_n(rst_n), .src_addr(src_addr), .dst_addr(dst_addr),
        .word_count(word_count), .start(start), .abort(abort), .fill_mode(fill_mode),
        .fill_pattern(fill_pattern), .busy(busy), .done(done), .err(err),
        .remaining(remaining), .br_n(br_n), .bg_n(bg_n), .bgack_n(bgack_n),
        .bus_as_n(bus_as_n), .m_oe(m_oe), .m_addr(m_addr), .m_fc(m_fc),
        .m_as_n(m_as_n), .m_rdh_n(m_rdh_n), .m_rdl_n(m_rdl_n), .m_wrh_n(m_wrh_n),
        .m_wrl_n(m_wrl_n), .m_data_out(m_data_out), .m_data_oe(m_data_oe),
        .m_data_in(m_data_in), .m_dtack_n(m_dtack_n)
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [22:0] addr;
        logic [15:0] data;
    } wr_t;

    int          n_checks = 0, n_pass = 0;
    int          cyc = 0;
    logic [15:0] mem [logic [22:0]];
    wr_t         exp_q[$];
    int          n_reads = 0, n_writes = 0, as_cnt = 0, as_low_cnt = 0;
    bit          resp_en = 1'b1;
    int          grant_delay = 1, as_hold = 0, req_cnt = 0, as_left = 0;
    int          t_br_fall = -1, t_bg_fall = -1, t_as_rise = -1, t_bgack_fall = -1;
    logic        prev_br_n = 1'b1, prev_bus_as_n = 1'b1, prev_bgack_n = 1'b1;
    logic [22:0] prev_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Arbiter, foreign-owner address strobe and memory responder, all on the falling edge.
    always @(negedge sysclk) begin
        wr_t e;
        cyc++;
        if (!br_n) begin
            if (prev_br_n) t_br_fall = cyc;
            req_cnt++;
            if (bg_n && req_cnt > grant_delay) begin
                bg_n      = 1'b0;
                as_left   = as_hold;
                t_bg_fall = cyc;
            end
        end else begin
            req_cnt = 0;
            bg_n    = 1'b1;
        end
        if (!bg_n && as_left > 0) begin
            bus_as_n = 1'b0;
            as_left--;
        end else if (!br_n && bg_n && as_hold > 0) bus_as_n = 1'b0;
        else bus_as_n = 1'b1;
        if (bus_as_n && !prev_bus_as_n) t_as_rise = cyc;
        if (!bgack_n && prev_bgack_n)   t_bgack_fall = cyc;
        prev_br_n     = br_n;
        prev_bus_as_n = bus_as_n;
        prev_bgack_n  = bgack_n;

        if (!m_as_n) as_low_cnt++;
        if (m_oe && !m_as_n) begin
            as_cnt++;
            if (as_cnt == 1) begin
                check("addr_setup", 32'(m_addr), 32'(prev_addr));
                check("fc", 32'(m_fc), 32'd5);
                if (!m_rdh_n) n_reads++;
                if (!m_wrh_n) n_writes++;
            end
            if (!m_rdh_n && !m_rdl_n) m_data_in = mem.exists(m_addr) ? mem[m_addr] : 16'h0;
            if (resp_en && as_cnt == 2) begin
                m_dtack_n = 1'b0;
                if (!m_wrh_n && !m_wrl_n) begin
                    if (exp_q.size() == 0) check("unexpected_write", 32'(m_addr), 32'hFFFF_FFFF);
                    else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(m_addr), 32'(e.addr));
                        check("wr_data", 32'(m_data_out), 32'(e.data));
                        check("wr_data_oe", 32'(m_data_oe), 32'd1);
                    end
                    mem[m_addr] = m_data_out;
                end
            end
        end else begin
            as_cnt    = 0;
            m_dtack_n = 1'b1;
        end
        prev_addr = m_addr;
    end

    task automatic pulse_start(input logic [22:0] s, input logic [22:0] d, input logic [15:0] n);
        src_addr   = s;
        dst_addr   = d;
        word_count = n;
        start      = 1'b1;
        @(negedge sysclk);
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k = 0;
        @(negedge sysclk);
        while ((busy || !(done || err)) && k < limit) begin
            @(negedge sysclk);
            k++;
        end
        check({tag, "_complete"}, 32'(k < limit), 32'd1);
        @(negedge sysclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w [4];
        int base_r, base_w, k;

        // Reset state
        repeat (3) @(negedge sysclk);
        check("rst_br_n",     32'(br_n),       32'd1);
        check("rst_bgack_n",  32'(bgack_n),    32'd1);
        check("rst_as_n",     32'(m_as_n),     32'd1);
        check("rst_lanes",    32'({m_rdh_n, m_rdl_n, m_wrh_n, m_wrl_n}), 32'hF);
        check("rst_oe",       32'({m_oe, m_data_oe}), 32'd0);
        check("rst_flags",    32'({busy, done, err}), 32'd0);
        check("rst_addr",     32'(m_addr),     32'd0);
        check("rst_data",     32'(m_data_out), 32'd0);
        check("rst_remaining",32'(remaining),  32'd0);
        check("rst_fc",       32'(m_fc),       32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);

        // Copy of 3 words, with an ignored start while busy
        for (int i = 0; i < 3; i++) begin
            w[i] = 16'($urandom);
            mem[23'h100 + 23'(i)] = w[i];
            exp_q.push_back('{addr: 23'h200 + 23'(i), data: w[i]});
        end
        base_r = n_reads;
        base_w = n_writes;
        pulse_start(23'h100, 23'h200, 16'd3);
        check("copy_br_latency", 32'(br_n), 32'd0);
        check("copy_busy",       32'(busy), 32'd1);
        pulse_start(23'h7, 23'h7, 16'd7);
        wait_idle("copy", 200);
        check("copy_done",      32'({done, err}), 32'b10);
        check("copy_remaining", 32'(remaining), 32'd0);
        check("copy_released",  32'({bgack_n, br_n, m_oe}), 32'b110);
        check("copy_reads",     32'(n_reads - base_r), 32'd3);
        check("copy_writes",    32'(n_writes - base_w), 32'd3);
        check("copy_q_empty",   32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 3; i++)
            check("copy_mem", 32'(mem[23'h200 + 23'(i)]), 32'(w[i]));

        // dtack timeout on the first read
        resp_en = 1'b0;
        base_r  = n_reads;
        base_w  = n_writes;
        as_low_cnt = 0;
        pulse_start(23'h300, 23'h380, 16'd2);
        wait_idle("tmo", 600);
        check("tmo_strobe_cycles", 32'(as_low_cnt), 32'd255);
        check("tmo_flags",     32'({done, err}), 32'b01);
        check("tmo_released",  32'({bgack_n, m_oe, m_as_n, m_rdh_n}), 32'b1011);
        check("tmo_remaining", 32'(remaining), 32'd2);
        check("tmo_writes",    32'(n_writes - base_w), 32'd0);
        check("tmo_reads",     32'(n_reads - base_r), 32'd1);
        resp_en = 1'b1;
        repeat (2) @(negedge sysclk);

        // Zero count: done next cycle, bus untouched, err cleared
        pulse_start(23'h10, 23'h20, 16'd0);
        check("zero_flags", 32'({busy, done, err}), 32'b010);
        check("zero_br_n",  32'(br_n), 32'd1);
        repeat (5) @(negedge sysclk);
        check("zero_br_n_later", 32'(br_n), 32'd1);
        check("zero_t_br",  32'(bgack_n), 32'd1);

        // Abort during the third write of 8
        for (int i = 0; i < 8; i++) mem[23'h400 + 23'(i)] = 16'h1000 + 16'(i);
        for (int i = 0; i < 3; i++) exp_q.push_back('{addr: 23'h500 + 23'(i), data: 16'h1000 + 16'(i)});
        base_w = n_writes;
        pulse_start(23'h400, 23'h500, 16'd8);
        k = 0;
        while (n_writes < base_w + 3 && k < 300) begin
            @(negedge sysclk);
            k++;
        end
        check("abort_reached_3rd", 32'(k < 300), 32'd1);
        abort = 1'b1;
        wait_idle("abort", 200);
        abort = 1'b0;
        check("abort_remaining", 32'(remaining), 32'd5);
        check("abort_flags",     32'({done, err}), 32'b10);
        check("abort_writes",    32'(n_writes - base_w), 32'd3);
        check("abort_q_empty",   32'(exp_q.size()), 32'd0);

        // Arbitration: late grant, previous owner still strobing
        grant_delay = 20;
        as_hold     = 2;
        t_br_fall = -1; t_bg_fall = -1; t_as_rise = -1; t_bgack_fall = -1;
        mem[23'h600] = 16'hBEEF;
        exp_q.push_back('{addr: 23'h680, data: 16'hBEEF});
        pulse_start(23'h600, 23'h680, 16'd1);
        wait_idle("arb", 200);
        check("arb_grant_delay",  32'(t_bg_fall - t_br_fall >= 20), 32'd1);
        check("arb_as_to_bgack",  32'(t_bgack_fall - t_as_rise), 32'd3);
        check("arb_bg_to_bgack",  32'(t_bgack_fall - t_bg_fall >= 3), 32'd1);
        check("arb_done",         32'(done), 32'd1);
        check("arb_q_empty",      32'(exp_q.size()), 32'd0);
        grant_delay = 1;
        as_hold     = 0;

`ifdef DMA_FILL_EN
        // Fill with destination wrap, no reads expected
        fill_mode    = 1'b1;
        fill_pattern = 16'hA5A5;
        exp_q.push_back('{addr: 23'h7FFFFF, data: 16'hA5A5});
        exp_q.push_back('{addr: 23'h000000, data: 16'hA5A5});
        base_r = n_reads;
        pulse_start(23'h10, 23'h7FFFFF, 16'd2);
        fill_mode = 1'b0;
        wait_idle("fill", 200);
        check("fill_reads", 32'(n_reads - base_r), 32'd0);
`else
        // fill_mode is ignored in this build: a normal copy with source wrap
        fill_mode    = 1'b1;
        fill_pattern = 16'hA5A5;
        mem[23'h7FFFFF] = 16'h1234;
        mem[23'h000000] = 16'h5678;
        exp_q.push_back('{addr: 23'h40, data: 16'h1234});
        exp_q.push_back('{addr: 23'h41, data: 16'h5678});
        base_r = n_reads;
        pulse_start(23'h7FFFFF, 23'h40, 16'd2);
        fill_mode = 1'b0;
        wait_idle("nofill", 200);
        check("nofill_reads", 32'(n_reads - base_r), 32'd2);
`endif
        check("fill_q_empty",  32'(exp_q.size()), 32'd0);
        check("fill_done",     32'({done, err}), 32'b10);
        check("fill_remaining",32'(remaining), 32'd0);

        // Reset in the middle of a transfer
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 23'h700 + 23'(i), data: 16'h0});
        pulse_start(23'h7F0, 23'h700, 16'd4);
        k = 0;
        while (m_as_n && k < 100) begin
            @(negedge sysclk);
            k++;
        end
        check("mid_reached_strobe", 32'(k < 100), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bus",   32'({br_n, bgack_n, m_as_n, m_oe, m_data_oe}), 32'b11100);
        check("mid_rst_flags", 32'({busy, done, err}), 32'd0);
        check("mid_rst_rem",   32'(remaining), 32'd0);
        check("mid_rst_addr",  32'(m_addr), 32'd0);
        exp_q.delete();
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
